// File: rtl/npc_pkg.sv
// Shared definitions for the NPC RV pipeline.
// Holds the default datapath widths, the load opcode, and the layout of the
// packed decoded-control bundle that travels from decode into execute.
package npc_pkg;

    localparam int NPC_XLEN       = 32;
    localparam int NPC_REG_ADDR_W = 5;
    localparam int NPC_CTRL_W     = 16;

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    // Bit offsets of each field inside the control bundle (LSB positions).
    localparam int CTRL_ALUASRC_LSB  = 0;   // 1 bit
    localparam int CTRL_ALUBSRC_LSB  = 1;   // 2 bits
    localparam int CTRL_ALUCTR_LSB   = 3;   // 4 bits
    localparam int CTRL_BRANCH_LSB   = 7;   // 3 bits
    localparam int CTRL_REGWR_LSB    = 10;  // 1 bit
    localparam int CTRL_MEMTOREG_LSB = 11;  // 1 bit
    localparam int CTRL_MEMWR_LSB    = 12;  // 1 bit
    localparam int CTRL_MEMOP_LSB    = 13;  // 3 bits

    // Same layout as the offsets above, MSB first.
    typedef struct packed {
        logic [2:0] memop;
        logic       memwr;
        logic       memtoreg;
        logic       regwr;
        logic [2:0] branch;
        logic [3:0] aluctr;
        logic [1:0] alubsrc;
        logic       aluasrc;
    } ctrl_t;

endpackage

// File: rtl/id_operand_bypass.sv
// Operand select for one register-file read port.
// x0 always reads as zero; a register being written back this cycle is taken
// from the write-back bus (write-through), otherwise the regfile data is used.
// Ports:
//   rs_i        source register address
//   rf_rdata_i  asynchronous regfile read data for rs_i
//   wb_we_i     write-back enable
//   wb_rd_i     write-back destination
//   wb_data_i   write-back data
//   operand_o   selected operand
module id_operand_bypass
    import npc_pkg::*;
#(
    parameter int XLEN       = NPC_XLEN,
    parameter int REG_ADDR_W = NPC_REG_ADDR_W,
    parameter bit WB_BYPASS  = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [XLEN-1:0]       rf_rdata_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]       wb_data_i,
    output logic [XLEN-1:0]       operand_o
);

    always_comb begin
        operand_o = rf_rdata_i;
        if (rs_i == '0) begin
            operand_o = '0;
        end else if (WB_BYPASS && wb_we_i && (wb_rd_i == rs_i)) begin
            operand_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register with valid/ready handshake, flush,
// load-use interlock (one bubble per load-use pair), write-back bypass on the
// regfile read data and a saturating count of interlock stall cycles.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid / in_ready           decode-side handshake
//   in_*                          decoded instruction fields
//   rf_rdata1/2                   regfile read data for rs1/rs2
//   wb_we / wb_rd / wb_data       write-back port (bypass source)
//   flush                         kill EX slot, do not consume decode slot
//   out_valid / out_ready         execute-side handshake
//   out_*                         registered payload
//   hazard                        combinational load-use interlock
//   stall_cnt                     saturating count of interlock bubbles
module id_ex_stage_reg
    import npc_pkg::*;
#(
    parameter int XLEN           = NPC_XLEN,
    parameter int REG_ADDR_W     = NPC_REG_ADDR_W,
    parameter int CTRL_W         = NPC_CTRL_W,
    parameter bit LOAD_USE_STALL = 1'b1,
    parameter bit WB_BYPASS      = 1'b1,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_instr,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_rs1_used,
    input  logic                  in_rs2_used,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic                  in_mem_rd,
    input  logic [XLEN-1:0]       in_imm,
    input  logic                  in_diffen,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_instr,
    output logic [XLEN-1:0]       out_imm,
    output logic [XLEN-1:0]       out_busa,
    output logic [XLEN-1:0]       out_busb,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic                  out_mem_rd,
    output logic                  out_diffen,
    output logic                  hazard,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int PAY_W = 5*XLEN + 3*REG_ADDR_W + CTRL_W + 2;

    logic [XLEN-1:0]  busa, busb;
    logic [PAY_W-1:0] pay_in, pay_d, pay_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             adv, rs_match;

    id_operand_bypass #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .WB_BYPASS(WB_BYPASS)) u_byp_rs1 (
        .rs_i(in_rs1), .rf_rdata_i(rf_rdata1), .wb_we_i(wb_we), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .operand_o(busa)
    );

    id_operand_bypass #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .WB_BYPASS(WB_BYPASS)) u_byp_rs2 (
        .rs_i(in_rs2), .rf_rdata_i(rf_rdata2), .wb_we_i(wb_we), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .operand_o(busb)
    );

    assign pay_in = {in_pc, in_instr, in_imm, busa, busb, in_rs1, in_rs2, in_rd,
                     in_ctrl, in_mem_rd, in_diffen};
    assign {out_pc, out_instr, out_imm, out_busa, out_busb, out_rs1, out_rs2, out_rd,
            out_ctrl, out_mem_rd, out_diffen} = pay_q;
    assign out_valid = valid_q;
    assign stall_cnt = cnt_q;

    assign adv      = !valid_q || out_ready;
    assign rs_match = (in_rs1_used && (in_rs1 == out_rd)) || (in_rs2_used && (in_rs2 == out_rd));
    // Raised even under back-pressure so upstream sees the dependency early;
    // it is only counted when the stage actually advances.
    assign hazard   = LOAD_USE_STALL && in_valid && valid_q && out_mem_rd &&
                      (out_rd != '0) && rs_match;
    assign in_ready = adv && !hazard && !flush;

    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            pay_d   = '0;
        end else if (adv) begin
            if (hazard) begin
                // Bubble: the load moves on to EX, so the hazard drops next cycle.
                valid_d = 1'b0;
                pay_d   = '0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else if (in_valid) begin
                valid_d = 1'b1;
                pay_d   = pay_in;
            end else begin
                valid_d = 1'b0;
                pay_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_instr, in_imm, rf_rdata1, rf_rdata2, wb_data;
    logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd;
    logic        in_rs1_used, in_rs2_used, in_mem_rd, in_diffen, wb_we, flush;
    logic [15:0] in_ctrl;
    logic        out_valid, out_ready, out_mem_rd, out_diffen, hazard;
    logic [31:0] out_pc, out_instr, out_imm, out_busa, out_busb;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [15:0] out_ctrl;
    logic [1:0]  stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(32), .REG_ADDR_W(5), .CTRL_W(16), .LOAD_USE_STALL(1'b1),
                      .WB_BYPASS(1'b1), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_ctrl(in_ctrl),
        .in_mem_rd(in_mem_rd), .in_imm(in_imm), .in_diffen(in_diffen),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_imm(out_imm), .out_busa(out_busa),
        .out_busb(out_busb), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_ctrl(out_ctrl), .out_mem_rd(out_mem_rd), .out_diffen(out_diffen),
        .hazard(hazard), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [31:0] pc, instr, imm, busa, busb;
        logic [4:0]  rs1, rs2, rd;
        logic [15:0] ctrl;
        logic        mem_rd, diffen;
    } exp_t;

    exp_t sb[$];       // expected EX-slot contents, in issue order
    exp_t ex_m;        // model's view of the instruction sitting in EX
    bit   ex_occ = 0;
    int   m_stall = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] opsel(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        if (wb_we && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    function automatic bit m_haz();
        return in_valid && ex_occ && ex_m.mem_rd && ex_m.rd != 5'd0 &&
               ((in_rs1_used && in_rs1 == ex_m.rd) || (in_rs2_used && in_rs2 == ex_m.rd));
    endfunction

    // Reference model: tracks what occupies EX and what the EXU should receive.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            sb.delete();
            ex_occ  = 0;
            m_stall = 0;
        end else begin
            bit   adv, hz;
            exp_t e;
            adv = !ex_occ || out_ready;
            hz  = m_haz();
            if (flush) begin
                // an undelivered EX instruction is killed
                if (ex_occ && !out_ready) e = sb.pop_front();
                ex_occ = 0;
            end else if (adv) begin
                if (hz) begin
                    ex_occ = 0;
                    if (m_stall < 3) m_stall++;
                end else if (in_valid) begin
                    e.pc = in_pc; e.instr = in_instr; e.imm = in_imm;
                    e.busa = opsel(in_rs1, rf_rdata1); e.busb = opsel(in_rs2, rf_rdata2);
                    e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd; e.ctrl = in_ctrl;
                    e.mem_rd = in_mem_rd; e.diffen = in_diffen;
                    sb.push_back(e);
                    ex_m   = e;
                    ex_occ = 1;
                end else begin
                    ex_occ = 0;
                end
            end
        end
    end

    // Monitor: compares whatever the DUT presents, pops on delivery.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("out_valid", out_valid, ex_occ);
            chk("hazard", hazard, m_haz());
            chk("in_ready", in_ready, (!ex_occ || out_ready) && !m_haz() && !flush);
            chk("stall_cnt", stall_cnt, m_stall);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb[0];
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instr", out_instr, e.instr);
                    chk("out_imm", out_imm, e.imm);
                    chk("out_busa", out_busa, e.busa);
                    chk("out_busb", out_busb, e.busb);
                    chk("out_regs", {out_rs1, out_rs2, out_rd}, {e.rs1, e.rs2, e.rd});
                    chk("out_ctrl", out_ctrl, e.ctrl);
                    chk("out_flags", {out_mem_rd, out_diffen}, {e.mem_rd, e.diffen});
                    if (out_ready) e = sb.pop_front();
                end
            end else begin
                chk("bubble_payload", out_pc | out_busa | out_busb | out_imm | {16'd0, out_ctrl}, 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_pc = 0; in_instr = 0; in_imm = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_used = 0; in_rs2_used = 0; in_ctrl = 0; in_mem_rd = 0; in_diffen = 0;
        rf_rdata1 = 0; rf_rdata2 = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic issue_load(input logic [4:0] rd);
        idle();
        in_valid = 1; in_mem_rd = 1; in_rd = rd; in_ctrl = 16'h0400; in_pc = 32'h200;
    endtask

    task automatic load_use(input bit check_cnt, input int exp_cnt);
        issue_load(5'd5);
        cyc();
        idle();
        in_valid = 1; in_rs2 = 5; in_rs2_used = 1; in_rd = 6; in_ctrl = 16'h0001; in_pc = 32'h204;
        #1;
        chk("lu_hazard", hazard, 1);
        chk("lu_in_ready", in_ready, 0);
        cyc();
        chk("lu_bubble_valid", out_valid, 0);
        chk("lu_bubble_ctrl", out_ctrl, 0);
        if (check_cnt) chk("lu_stall_cnt", stall_cnt, exp_cnt);
        cyc();
        chk("lu_issue_valid", out_valid, 1);
        chk("lu_issue_rd", out_rd, 6);
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_diffen", out_diffen, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1;

        // plain flow
        in_valid = 1; in_pc = 32'h8000_0000; in_rs1 = 3; in_rs1_used = 1; rf_rdata1 = 32'h11;
        in_diffen = 1;
        #1 chk("plain_in_ready", in_ready, 1);
        cyc();
        chk("plain_valid", out_valid, 1);
        chk("plain_pc", out_pc, 32'h8000_0000);
        chk("plain_busa", out_busa, 32'h11);
        idle();
        cyc();

        // load-use: one bubble, counter 0 -> 1
        load_use(1, 1);

        // not hazards
        issue_load(5'd0);
        cyc();
        idle(); in_valid = 1; in_rs1 = 0; in_rs1_used = 1;
        #1 chk("nohaz_rd0", hazard, 0);
        cyc();
        issue_load(5'd5);
        cyc();
        idle(); in_valid = 1; in_rs1 = 5; in_rs1_used = 0;
        #1 chk("nohaz_unused", hazard, 0);
        cyc();

        // write-back bypass
        idle(); in_valid = 1; wb_we = 1; wb_rd = 7; wb_data = 32'hDEAD_BEEF; in_rs1 = 7;
        cyc();
        chk("byp_busa", out_busa, 32'hDEAD_BEEF);
        wb_rd = 0; in_rs1 = 0;
        cyc();
        chk("byp_x0", out_busa, 0);

        // back-pressure then flush
        idle(); in_valid = 1; in_pc = 32'h100;
        cyc();
        out_ready = 0; in_pc = 32'h104;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_pc_stable", out_pc, 32'h100);
        end
        flush = 1;
        cyc();
        chk("flush_valid", out_valid, 0);
        chk("flush_pc", out_pc, 0);
        idle();

        // flush together with a hazard must not count
        issue_load(5'd5);
        cyc();
        idle(); in_valid = 1; in_rs1 = 5; in_rs1_used = 1; flush = 1;
        cyc();
        chk("flush_haz_cnt", stall_cnt, 1);
        idle();

        // saturation at 3
        for (int i = 0; i < 4; i++) load_use(0, 0);
        chk("sat_cnt", stall_cnt, 3);

        // asynchronous reset mid-operation
        idle(); in_valid = 1; in_pc = 32'h300;
        cyc();
        idle();
        #2 rst_n = 0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_pc", out_pc, 0);
        chk("async_cnt", stall_cnt, 0);
        #3 rst_n = 1;
        cyc();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 4) != 0);
            in_pc       = $urandom; in_instr = $urandom; in_imm = $urandom;
            in_rs1      = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
            in_rd       = 5'($urandom_range(0, 7));
            in_rs1_used = 1'($urandom); in_rs2_used = 1'($urandom);
            in_ctrl     = 16'($urandom); in_mem_rd = ($urandom_range(0, 2) == 0);
            in_diffen   = 1'($urandom);
            rf_rdata1   = $urandom; rf_rdata2 = $urandom;
            wb_we       = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            flush       = ($urandom_range(0, 15) == 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            cyc();
        end
        idle();
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
Parametrised decode-to-execute pipeline stage for the NPC RV pipeline, placed between the predecoder/decoder and the EXU. It replaces the free-running ID/EX register with a valid/ready handshake and a flush input. It adds a load-use interlock that inserts a bubble, and a write-back write-through bypass on the register-file read data. It also keeps a saturating count of interlock stall cycles for performance checks.

Parameters:
XLEN, 32, data/PC/instruction/immediate width
REG_ADDR_W, 5, register address width
CTRL_W, 16, width of the packed decoded control bundle (ALU src/ctr, branch, regwr, memtoreg, memwr, memop)
LOAD_USE_STALL, 1, 1 = interlock enabled; 0 = hazard forced low
WB_BYPASS, 1, 1 = write-through bypass enabled; 0 = raw regfile data
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode slot holds an instruction
in_ready  out  1  stage accepts the decode slot this cycle
in_pc  in  XLEN  instruction PC
in_instr  in  XLEN  raw instruction
in_rs1, in_rs2, in_rd  in  REG_ADDR_W  register addresses
in_rs1_used, in_rs2_used  in  1  operand actually read by the instruction
in_ctrl  in  CTRL_W  decoded control bundle
in_mem_rd  in  1  instruction is a load
in_imm  in  XLEN  generated immediate
in_diffen  in  1  difftest commit tag
rf_rdata1, rf_rdata2  in  XLEN  asynchronous regfile read data for rs1/rs2
wb_we  in  1  write-back register write enable
wb_rd  in  REG_ADDR_W  write-back destination
wb_data  in  XLEN  write-back data
flush  in  1  branch-mispredict/redirect kill
out_valid  out  1  EX slot valid
out_ready  in  1  EXU accepts the EX slot
out_pc, out_instr, out_imm, out_busa, out_busb  out  XLEN  registered payload
out_rs1, out_rs2, out_rd  out  REG_ADDR_W  registered addresses
out_ctrl  out  CTRL_W  registered control bundle
out_mem_rd  out  1  registered load flag
out_diffen  out  1  registered difftest tag
hazard  out  1  load-use interlock active this cycle (combinational)
stall_cnt  out  CNT_W  saturating interlock-stall cycle count

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, including out_valid, out_diffen and stall_cnt. in_ready follows from its equation.
- Advance condition: adv = !out_valid || out_ready.
- Hazard term: hazard = LOAD_USE_STALL && in_valid && out_valid && out_mem_rd && out_rd != 0 && ((in_rs1_used && in_rs1 == out_rd) || (in_rs2_used && in_rs2 == out_rd)).
- Ready: in_ready = adv && !hazard && !flush.
- Per-cycle priority, evaluated at each clk rising edge: flush > (adv && hazard) > (adv && in_valid) > (adv && !in_valid) > hold.
  - flush: out_valid is 0 next cycle and all payload is cleared to 0; the decode slot is not consumed, because upstream is flushed by the same signal.
  - adv && hazard: insert a bubble (out_valid 0, payload 0) and do not consume the decode slot. The load leaves EX, so the hazard clears the following cycle: exactly one bubble per load-use pair.
  - adv && in_valid && !hazard: capture all in_* fields plus the bypassed operands; out_valid is 1.
  - adv && !in_valid: out_valid is 0 and payload is 0.
  - !adv: all outputs hold unchanged, including during flush-free back-pressure.
- Operand select, per operand: if rs == 0, the operand is 0. Else if WB_BYPASS && wb_we && wb_rd == rs, the operand is wb_data. Otherwise it is rf_rdata.
- stall_cnt increments by 1 on each edge where adv && hazard && !flush, and saturates at all-ones.
- hazard is asserted combinationally even when !adv, but counts only on advancing cycles.
- Latency: 1 cycle from acceptance to out_valid.

Decomposition:
- Shared package npc_pkg:
  - XLEN and REG_ADDR_W defaults.
  - Opcode constant OP_LOAD = 7'b0000011.
  - Packed control-bundle typedef of CTRL_W, with field offsets for ALUAsrc, ALUBsrc, ALUctr, Branch, RegWr, MemtoReg, MemWr, MemOp.
- One sub-module, id_operand_bypass: combinational zero/bypass mux, instantiated once each for rs1 and rs2.
- Pipeline register, handshake and counter stay in the top module.

Test Plan:
- Plain flow: rst_n low, then high; in_valid=1, pc=0x80000000, rs1=3, rf_rdata1=0x11, out_ready=1 -> next cycle out_valid=1, out_pc=0x80000000, out_busa=0x11, in_ready=1 throughout.
- Load-use: EX holds a load with rd=5; next instruction has rs2=5 and rs2_used=1 -> hazard=1, in_ready=0, one bubble (out_valid=0, out_ctrl=0). The instruction issues the following cycle, and stall_cnt goes from 0 to 1.
- Not a hazard:
  - Load rd=0 followed by rs1=0 -> no bubble.
  - Load rd=5 followed by rs1=5 with rs1_used=0 -> no bubble.
- WB bypass: wb_we=1, wb_rd=7, wb_data=0xDEADBEEF, in_rs1=7, rf_rdata1=0x0 -> out_busa=0xDEADBEEF. Same stimulus with wb_rd=0 and rs1=0 -> out_busa=0.
- Back-pressure then flush: out_ready=0 for 3 cycles -> outputs stable and in_ready=0. Then assert flush with out_ready=0 -> next cycle out_valid=0 and payload 0. Flush together with a hazard must not increment stall_cnt.
- Reset mid-operation and saturation: drop rst_n asynchronously while out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge. With CNT_W=2, four or more stall cycles -> stall_cnt holds at 3.
